// File: rtl/calc_sequencer.sv
// calc_sequencer: key-driven operand entry and ALU sequencing for the 16-bit signed calculator.
// Optional ALU watchdog is built in when CALC_ALU_TIMEOUT_EN is defined.
module calc_sequencer #(
    parameter int ALU_TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        read_input_i,
    output logic        key_read_o,
    input  logic [3:0]  keypad_input_i,
    input  logic [2:0]  operator_input_i,
    input  logic        equal_input_i,
    output logic [15:0] alu_a_o,
    output logic [15:0] alu_b_o,
    output logic [1:0]  alu_op_o,
    output logic        alu_start_o,
    input  logic        alu_done_i,
    input  logic [15:0] alu_result_i,
    input  logic        alu_ovf_i,
    output logic [15:0] display_value_o,
    output logic        display_err_o
);

    typedef enum logic [2:0] {
        S_ENTER_A  = 3'd0,
        S_ENTER_B  = 3'd1,
        S_WAIT_ALU = 3'd2,
        S_SHOW_RES = 3'd3,
        S_ERROR    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic [14:0] mag_q, mag_d;
    logic        neg_q, neg_d;
    logic        has_digit_q, has_digit_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] res_q, res_d;
    logic        key_read_q, key_read_d;
    logic        alu_start_q, alu_start_d;

`ifdef CALC_ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic        accept;
    logic        is_eq, is_neg, is_op, is_dig;
    logic [1:0]  op_sel;
    logic [15:0] entry_val;
    logic [18:0] mag_next;
    logic        digit_fits;

    assign accept     = read_input_i && armed_q && (state_q != S_WAIT_ALU);
    assign is_eq      = equal_input_i;
    assign is_neg     = !equal_input_i && (operator_input_i == 3'b001);
    assign is_op      = !equal_input_i && (operator_input_i == 3'b010 ||
                                           operator_input_i == 3'b011 ||
                                           operator_input_i == 3'b100);
    assign is_dig     = !equal_input_i && (operator_input_i == 3'b000);
    assign entry_val  = neg_q ? (16'd0 - {1'b0, mag_q}) : {1'b0, mag_q};
    assign mag_next   = {4'b0, mag_q} * 19'd10 + {15'b0, keypad_input_i};
    assign digit_fits = (mag_next <= 19'd32767);

    always_comb begin
        case (operator_input_i)
            3'b011:  op_sel = 2'b01;
            3'b100:  op_sel = 2'b10;
            default: op_sel = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_ENTER_A;
            armed_q     <= 1'b0;
            mag_q       <= '0;
            neg_q       <= 1'b0;
            has_digit_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            res_q       <= '0;
            key_read_q  <= 1'b0;
            alu_start_q <= 1'b0;
`ifdef CALC_ALU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            mag_q       <= mag_d;
            neg_q       <= neg_d;
            has_digit_q <= has_digit_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            res_q       <= res_d;
            key_read_q  <= key_read_d;
            alu_start_q <= alu_start_d;
`ifdef CALC_ALU_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        neg_d       = neg_q;
        has_digit_d = has_digit_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_d       = res_q;
        key_read_d  = accept;
        alu_start_d = 1'b0;
`ifdef CALC_ALU_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        // A held key is consumed once; it must be released before the next one counts.
        if (accept)
            armed_d = 1'b0;
        else if (!read_input_i)
            armed_d = 1'b1;
        else
            armed_d = armed_q;

        case (state_q)
            S_ENTER_A, S_ENTER_B: begin
                if (accept) begin
                    if (is_eq) begin
                        if (state_q == S_ENTER_B && has_digit_q) begin
                            b_d         = entry_val;
                            alu_start_d = 1'b1;
                            state_d     = S_WAIT_ALU;
`ifdef CALC_ALU_TIMEOUT_EN
                            cnt_d       = CNT_W'(ALU_TIMEOUT);
`endif
                        end
                    end else if (is_neg) begin
                        neg_d = !neg_q;
                    end else if (is_op) begin
                        if (state_q == S_ENTER_A) begin
                            a_d         = entry_val;
                            op_d        = op_sel;
                            mag_d       = '0;
                            neg_d       = 1'b0;
                            has_digit_d = 1'b0;
                            state_d     = S_ENTER_B;
                        end else if (!has_digit_q) begin
                            op_d = op_sel;
                        end
                    end else if (is_dig) begin
                        if (digit_fits)
                            mag_d = mag_next[14:0];
                        has_digit_d = 1'b1;
                    end
                end
            end
            S_WAIT_ALU: begin
                if (alu_done_i) begin
                    if (alu_ovf_i) begin
                        state_d = S_ERROR;
                    end else begin
                        res_d   = alu_result_i;
                        state_d = S_SHOW_RES;
                    end
`ifdef CALC_ALU_TIMEOUT_EN
                end else if (cnt_q == '0) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
`endif
                end
            end
            S_SHOW_RES, S_ERROR: begin
                if (accept) begin
                    if (is_dig) begin
                        a_d         = '0;
                        b_d         = '0;
                        op_d        = '0;
                        res_d       = '0;
                        mag_d       = {11'b0, keypad_input_i};
                        neg_d       = 1'b0;
                        has_digit_d = 1'b1;
                        state_d     = S_ENTER_A;
                    end else if (state_q == S_SHOW_RES && is_neg) begin
                        // -32768 has no positive counterpart in 16 bits.
                        if (res_q == 16'h8000) begin
                            state_d = S_ERROR;
                        end else begin
                            mag_d       = res_q[15] ? (15'd0 - res_q[14:0]) : res_q[14:0];
                            neg_d       = !res_q[15] && (res_q != 16'd0);
                            has_digit_d = 1'b1;
                            state_d     = S_ENTER_A;
                        end
                    end else if (state_q == S_SHOW_RES && is_op) begin
                        a_d         = res_q;
                        op_d        = op_sel;
                        mag_d       = '0;
                        neg_d       = 1'b0;
                        has_digit_d = 1'b0;
                        state_d     = S_ENTER_B;
                    end
                end
            end
            default: state_d = S_ENTER_A;
        endcase
    end

    always_comb begin
        display_value_o = 16'd0;
        display_err_o   = 1'b0;
        case (state_q)
            S_ENTER_A, S_ENTER_B: display_value_o = entry_val;
            S_SHOW_RES:           display_value_o = res_q;
            S_ERROR:              display_err_o   = 1'b1;
            default:              display_value_o = 16'd0;
        endcase
    end

    assign key_read_o  = key_read_q;
    assign alu_start_o = alu_start_q;
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign alu_op_o    = op_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed key sequences plus random key streams checked against a key-level model.
module tb_calc_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        read_input_i = 1'b0;
    logic        key_read_o;
    logic [3:0]  keypad_input_i = '0;
    logic [2:0]  operator_input_i = '0;
    logic        equal_input_i = 1'b0;
    logic [15:0] alu_a_o, alu_b_o;
    logic [1:0]  alu_op_o;
    logic        alu_start_o;
    logic        alu_done_i = 1'b0;
    logic [15:0] alu_result_i = '0;
    logic        alu_ovf_i = 1'b0;
    logic [15:0] display_value_o;
    logic        display_err_o;

    calc_sequencer dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .read_input_i    (read_input_i),
        .key_read_o      (key_read_o),
        .keypad_input_i  (keypad_input_i),
        .operator_input_i(operator_input_i),
        .equal_input_i   (equal_input_i),
        .alu_a_o         (alu_a_o),
        .alu_b_o         (alu_b_o),
        .alu_op_o        (alu_op_o),
        .alu_start_o     (alu_start_o),
        .alu_done_i      (alu_done_i),
        .alu_result_i    (alu_result_i),
        .alu_ovf_i       (alu_ovf_i),
        .display_value_o (display_value_o),
        .display_err_o   (display_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_bad   = 0;
    int kr_count = 0;

    always @(posedge clk_i) if (key_read_o) kr_count++;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Key-level model: one update per acknowledged key / ALU completion.
    localparam int M_EA = 0, M_EB = 1, M_WT = 2, M_SH = 3, M_ER = 4;
    int m_mode, m_mag, m_neg, m_hd, m_a, m_b, m_op, m_res;

    function automatic int entry();
        return (m_neg != 0) ? -m_mag : m_mag;
    endfunction

    function automatic int exp_disp();
        if (m_mode == M_EA || m_mode == M_EB) return entry();
        if (m_mode == M_SH) return m_res;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = M_EA; m_mag = 0; m_neg = 0; m_hd = 0;
        m_a = 0; m_b = 0; m_op = 0; m_res = 0;
    endtask

    task automatic model_key(input bit eq, input logic [2:0] opc, input int d, output bit start);
        int v;
        start = 0;
        if (eq) begin
            if (m_mode == M_EB && m_hd != 0) begin
                m_b = entry(); start = 1; m_mode = M_WT;
            end
        end else if (opc == 3'd1) begin
            if (m_mode == M_EA || m_mode == M_EB) m_neg = (m_neg != 0) ? 0 : 1;
            else if (m_mode == M_SH) begin
                if (m_res == -32768) m_mode = M_ER;
                else begin
                    v = -m_res;
                    m_mag = (v < 0) ? -v : v;
                    m_neg = (v < 0) ? 1 : 0;
                    m_hd = 1; m_mode = M_EA;
                end
            end
        end else if (opc >= 3'd2 && opc <= 3'd4) begin
            if (m_mode == M_EA) begin
                m_a = entry(); m_op = int'(opc) - 2;
                m_mag = 0; m_neg = 0; m_hd = 0; m_mode = M_EB;
            end else if (m_mode == M_EB) begin
                if (m_hd == 0) m_op = int'(opc) - 2;
            end else if (m_mode == M_SH) begin
                m_a = m_res; m_op = int'(opc) - 2;
                m_mag = 0; m_neg = 0; m_hd = 0; m_mode = M_EB;
            end
        end else if (opc == 3'd0) begin
            if (m_mode == M_EA || m_mode == M_EB) begin
                if (m_mag * 10 + d <= 32767) m_mag = m_mag * 10 + d;
                m_hd = 1;
            end else if (m_mode == M_SH || m_mode == M_ER) begin
                m_a = 0; m_b = 0; m_op = 0; m_res = 0;
                m_mag = d; m_neg = 0; m_hd = 1; m_mode = M_EA;
            end
        end
    endtask

    task automatic check_display(input string tag);
        chk_eq({tag, "_disp"}, int'($signed(display_value_o)), exp_disp());
        chk_eq({tag, "_err"}, int'(display_err_o), (m_mode == M_ER) ? 1 : 0);
    endtask

    task automatic check_alu_operands(input string tag);
        chk_eq({tag, "_a"}, int'($signed(alu_a_o)), m_a);
        chk_eq({tag, "_b"}, int'($signed(alu_b_o)), m_b);
        chk_eq({tag, "_op"}, int'(alu_op_o), m_op);
    endtask

    task automatic check_all_zero(input string tag);
        chk_eq({tag, "_kr"}, int'(key_read_o), 0);
        chk_eq({tag, "_a"}, int'(alu_a_o), 0);
        chk_eq({tag, "_b"}, int'(alu_b_o), 0);
        chk_eq({tag, "_op"}, int'(alu_op_o), 0);
        chk_eq({tag, "_start"}, int'(alu_start_o), 0);
        chk_eq({tag, "_disp"}, int'(display_value_o), 0);
        chk_eq({tag, "_err"}, int'(display_err_o), 0);
    endtask

    task automatic key_press(input bit eq, input logic [2:0] opc, input int d, input string tag);
        bit got = 0;
        bit st;
        keypad_input_i   = 4'(d);
        operator_input_i = opc;
        equal_input_i    = eq;
        read_input_i     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (key_read_o) begin got = 1; break; end
        end
        chk_eq({tag, "_ack"}, int'(got), 1);
        model_key(eq, opc, d, st);
        chk_eq({tag, "_start"}, int'(alu_start_o), int'(st));
        if (st) check_alu_operands(tag);
        else    check_display(tag);
        read_input_i  = 1'b0;
        equal_input_i = 1'b0;
        tick();
        chk_eq({tag, "_kr_pulse"}, int'(key_read_o), 0);
        if (st) chk_eq({tag, "_start_pulse"}, int'(alu_start_o), 0);
    endtask

    task automatic alu_respond(input int dly, input bit force_ovf, input string tag);
        int r;
        bit ovf;
        case (m_op)
            0:       r = m_a + m_b;
            1:       r = m_a - m_b;
            default: r = m_a * m_b;
        endcase
        ovf = force_ovf || (r > 32767) || (r < -32768);
        repeat (dly) tick();
        alu_result_i = 16'(r);
        alu_ovf_i    = ovf;
        alu_done_i   = 1'b1;
        tick();
        alu_done_i = 1'b0;
        alu_ovf_i  = 1'b0;
        if (ovf) m_mode = M_ER;
        else begin m_res = r; m_mode = M_SH; end
        check_display(tag);
    endtask

    task automatic do_reset();
        read_input_i = 1'b0;
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        model_reset();
        tick();
    endtask

    initial begin
        int kr0, seen;
        bit got;
        int r, d;
        logic [2:0] opc;
        model_reset();
        repeat (3) tick();
        check_all_zero("reset");
        rst_ni = 1'b1;
        tick();

        // 12 + 3
        kr0 = kr_count;
        key_press(0, 3'b000, 1, "t1_d1");
        key_press(0, 3'b000, 2, "t1_d2");
        key_press(0, 3'b010, 0, "t1_add");
        key_press(0, 3'b000, 3, "t1_d3");
        key_press(1, 3'b000, 0, "t1_eq");
        chk_eq("t1_a_const", int'($signed(alu_a_o)), 12);
        chk_eq("t1_b_const", int'($signed(alu_b_o)), 3);
        chk_eq("t1_op_const", int'(alu_op_o), 0);
        alu_respond(0, 0, "t1_res");
        chk_eq("t1_res_const", int'($signed(display_value_o)), 15);
        chk_eq("t1_kr_count", kr_count - kr0, 5);

        // Fifth digit overflows 32767 and is dropped
        key_press(0, 3'b000, 3, "t2_d3");
        key_press(0, 3'b000, 2, "t2_d2");
        key_press(0, 3'b000, 7, "t2_d7");
        key_press(0, 3'b000, 6, "t2_d6");
        key_press(0, 3'b000, 8, "t2_d8");
        chk_eq("t2_cap", int'($signed(display_value_o)), 3276);

        // -5 * 4 with forced overflow, then recovery by digit
        do_reset();
        key_press(0, 3'b000, 5, "t3_d5");
        key_press(0, 3'b001, 0, "t3_neg");
        key_press(0, 3'b100, 0, "t3_mul");
        key_press(0, 3'b000, 4, "t3_d4");
        key_press(1, 3'b000, 0, "t3_eq");
        chk_eq("t3_a_const", int'($signed(alu_a_o)), -5);
        chk_eq("t3_op_const", int'(alu_op_o), 2);
        alu_respond(1, 1, "t3_ovf");
        chk_eq("t3_err_const", int'(display_err_o), 1);
        key_press(0, 3'b000, 7, "t3_d7");
        chk_eq("t3_d7_const", int'($signed(display_value_o)), 7);

        // read_input held for 20 cycles gives exactly one acknowledge
        keypad_input_i = 4'd1; operator_input_i = 3'b000; read_input_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (key_read_o) seen++;
        end
        read_input_i = 1'b0;
        begin bit st; model_key(0, 3'b000, 1, st); end
        chk_eq("t4_one_ack", seen, 1);
        check_display("t4");
        tick();

        // key pending during WAIT_ALU is held off until alu_done
        key_press(0, 3'b010, 0, "t5_add");
        key_press(0, 3'b000, 2, "t5_d2");
        key_press(1, 3'b000, 0, "t5_eq");
        keypad_input_i = 4'd9; operator_input_i = 3'b000; read_input_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (key_read_o) seen++;
        end
        chk_eq("t5_no_ack_wait", seen, 0);
        alu_respond(0, 0, "t5_res");
        got = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (key_read_o) begin got = 1; break; end
        end
        chk_eq("t5_ack_after_done", int'(got), 1);
        begin bit st; model_key(0, 3'b000, 9, st); end
        check_display("t5_d9");
        read_input_i = 1'b0;
        tick();

        // stray alu_done outside WAIT_ALU
        alu_result_i = 16'd1234; alu_done_i = 1'b1;
        tick();
        alu_done_i = 1'b0;
        tick();
        check_display("t6_stray_done");

        // reset during WAIT_ALU, late alu_done ignored
        key_press(0, 3'b100, 0, "t7_mul");
        key_press(0, 3'b000, 3, "t7_d3");
        key_press(1, 3'b000, 0, "t7_eq");
        rst_ni = 1'b0;
        #1;
        check_all_zero("t7_rst");
        #2;
        rst_ni = 1'b1;
        model_reset();
        tick();
        alu_result_i = 16'd27; alu_done_i = 1'b1;
        tick();
        alu_done_i = 1'b0;
        tick();
        check_display("t7_late_done");

`ifdef CALC_ALU_TIMEOUT_EN
        key_press(0, 3'b000, 4, "t8_d4");
        key_press(0, 3'b010, 0, "t8_add");
        key_press(0, 3'b000, 5, "t8_d5");
        key_press(1, 3'b000, 0, "t8_eq");
        repeat (63) tick();
        chk_eq("t8_before_expiry", int'(display_err_o), 0);
        tick();
        chk_eq("t8_timeout_err", int'(display_err_o), 1);
        m_mode = M_ER;
`endif

        // random key stream
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 99);
            d = $urandom_range(0, 9);
            opc = 3'($urandom_range(0, 7));
            if (r < 55)      key_press(0, 3'b000, d, "rnd_dig");
            else if (r < 65) key_press(0, 3'b001, d, "rnd_neg");
            else if (r < 80) key_press(0, 3'($urandom_range(2, 4)), d, "rnd_op");
            else if (r < 95) key_press(1, opc, d, "rnd_eq");
            else             key_press(0, 3'($urandom_range(5, 7)), d, "rnd_bad");
            if (m_mode == M_WT) alu_respond($urandom_range(0, 4), 0, "rnd_res");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
